// File: rtl/ntm_fnn_pkg.sv
// Shared definitions for the standard FNN layer sequencer: widths, op-codes,
// FSM state and phase enums, and small helpers for phase ordering.
package ntm_fnn_pkg;

    localparam int DATA_SIZE    = 64;
    localparam int CONTROL_SIZE = 4;

    typedef logic [CONTROL_SIZE-1:0] opcode_t;

    localparam opcode_t OP_MAC_W = opcode_t'(0);
    localparam opcode_t OP_MAC_K = opcode_t'(1);
    localparam opcode_t OP_MAC_U = opcode_t'(2);
    localparam opcode_t OP_ADD_B = opcode_t'(3);
    localparam opcode_t OP_ACT   = opcode_t'(4);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_STORE,
        ST_FINISH
    } state_e;

    typedef enum logic [2:0] {
        PH_W,
        PH_K,
        PH_U,
        PH_B,
        PH_ACT
    } phase_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // First phase of a neuron; U is never empty while a pass is running.
    function automatic phase_e first_phase(input logic x_empty, input logic r_empty);
        if (!x_empty) return PH_W;
        if (!r_empty) return PH_K;
        return PH_U;
    endfunction

    // Phase following a completed one, skipping an empty K phase.
    function automatic phase_e next_phase(input phase_e p, input logic r_empty);
        case (p)
            PH_W:    return r_empty ? PH_U : PH_K;
            PH_K:    return PH_U;
            PH_U:    return PH_B;
            default: return PH_ACT;
        endcase
    endfunction

    function automatic opcode_t phase_to_op(input phase_e p);
        case (p)
            PH_W:    return OP_MAC_W;
            PH_K:    return OP_MAC_K;
            PH_U:    return OP_MAC_U;
            PH_B:    return OP_ADD_B;
            default: return OP_ACT;
        endcase
    endfunction

endpackage

// File: rtl/ntm_fnn_index_counter.sv
// Bounded up-counter: counts 0..limit-1, flags the last value and wraps to 0.
module ntm_fnn_index_counter #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear has priority, increment wraps after limit-1.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        wrap    = (count_q == limit - W'(1));
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
            count_d = wrap ? '0 : count_q + W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state is written with <= so every flop samples pre-edge values, independent of block order.
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/ntm_fnn_sequencer.sv
// Standard-FNN layer sequencer: walks neurons l and operands j through the
// W, K, U, B and ACT phases, issuing one op at a time to a shared arithmetic
// unit, accumulating returned terms and writing each activated neuron output.
module ntm_fnn_sequencer #(
    parameter int   DATA_SIZE    = ntm_fnn_pkg::DATA_SIZE,
    parameter int   CONTROL_SIZE = ntm_fnn_pkg::CONTROL_SIZE,
    parameter int   X            = 64,
    parameter int   R            = 64,
    parameter int   L            = 64,
    localparam int  IW           = $clog2(ntm_fnn_pkg::max3(X, R, L) + 1)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    input  logic [IW-1:0]           SIZE_X_IN,
    input  logic [IW-1:0]           SIZE_R_IN,
    input  logic [IW-1:0]           SIZE_L_IN,
    output logic                    READY,
    output logic                    OP_VALID,
    input  logic                    OP_READY,
    output logic [CONTROL_SIZE-1:0] OP_CODE,
    output logic [IW-1:0]           OP_L,
    output logic [IW-1:0]           OP_J,
    output logic [DATA_SIZE-1:0]    OP_DATA,
    input  logic                    RESULT_VALID,
    input  logic [DATA_SIZE-1:0]    RESULT_IN,
    output logic                    H_OUT_ENABLE,
    output logic [IW-1:0]           H_OUT_L,
    output logic [DATA_SIZE-1:0]    H_OUT
);

    import ntm_fnn_pkg::*;

    function automatic logic [IW-1:0] clamp(input logic [IW-1:0] v, input int lim);
        return (int'(v) > lim) ? IW'(lim) : v;
    endfunction

    state_e                 state_q, state_d;
    phase_e                 phase_q, phase_d;
    logic [DATA_SIZE-1:0]   acc_q, acc_d;
    logic [DATA_SIZE-1:0]   act_q, act_d;
    logic [IW-1:0]          size_x_q, size_x_d;
    logic [IW-1:0]          size_r_q, size_r_d;
    logic [IW-1:0]          size_l_q, size_l_d;

    logic [IW-1:0]          cx, cr, cl;
    logic [IW-1:0]          j_limit, j_count, l_count;
    logic                   j_clear, j_inc, j_wrap;
    logic                   l_clear, l_inc, l_wrap;

    ntm_fnn_index_counter #(.W(IW)) u_j_cnt (
        .clk   (CLK),
        .rst   (RST),
        .clear (j_clear),
        .inc   (j_inc),
        .limit (j_limit),
        .count (j_count),
        .wrap  (j_wrap)
    );

    ntm_fnn_index_counter #(.W(IW)) u_l_cnt (
        .clk   (CLK),
        .rst   (RST),
        .clear (l_clear),
        .inc   (l_inc),
        .limit (size_l_q),
        .count (l_count),
        .wrap  (l_wrap)
    );

    // Operand count of the current phase; B and ACT issue a single op.
    always_comb begin
        cx = clamp(SIZE_X_IN, X);
        cr = clamp(SIZE_R_IN, R);
        cl = clamp(SIZE_L_IN, L);
        case (phase_q)
            PH_W:    j_limit = size_x_q;
            PH_K:    j_limit = size_r_q;
            PH_U:    j_limit = size_l_q;
            default: j_limit = IW'(1);
        endcase
    end

    // Next-state, phase, accumulator and counter control.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        acc_d    = acc_q;
        act_d    = act_q;
        size_x_d = size_x_q;
        size_r_d = size_r_q;
        size_l_d = size_l_q;
        j_clear  = 1'b0;
        j_inc    = 1'b0;
        l_clear  = 1'b0;
        l_inc    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    size_x_d = cx;
                    size_r_d = cr;
                    size_l_d = cl;
                    acc_d    = '0;
                    j_clear  = 1'b1;
                    l_clear  = 1'b1;
                    phase_d  = first_phase(cx == '0, cr == '0);
                    state_d  = (cl == '0) ? ST_FINISH : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (OP_READY) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (RESULT_VALID) begin
                    j_inc = 1'b1;
                    if (phase_q == PH_ACT) begin
                        act_d   = RESULT_IN;
                        state_d = ST_STORE;
                    end else begin
                        acc_d   = acc_q + RESULT_IN;
                        state_d = ST_ISSUE;
                        if (j_wrap) phase_d = next_phase(phase_q, size_r_q == '0);
                    end
                end
            end
            ST_STORE: begin
                acc_d   = '0;
                l_inc   = 1'b1;
                phase_d = first_phase(size_x_q == '0, size_r_q == '0);
                state_d = l_wrap ? ST_FINISH : ST_ISSUE;
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, phase, accumulator and latched-size registers.
    always_ff @(posedge CLK) begin
        // NOTE: the accumulator and result hold are datapath regs but must reset so an aborted pass leaves nothing behind.
        if (RST) begin
            state_q  <= ST_IDLE;
            phase_q  <= PH_W;
            acc_q    <= '0;
            act_q    <= '0;
            size_x_q <= '0;
            size_r_q <= '0;
            size_l_q <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            acc_q    <= acc_d;
            act_q    <= act_d;
            size_x_q <= size_x_d;
            size_r_q <= size_r_d;
            size_l_q <= size_l_d;
        end
    end

    // Moore outputs: request fields only in ISSUE, write port only in STORE.
    always_comb begin
        READY        = (state_q == ST_FINISH);
        OP_VALID     = (state_q == ST_ISSUE);
        OP_CODE      = '0;
        OP_L         = '0;
        OP_J         = '0;
        OP_DATA      = '0;
        H_OUT_ENABLE = 1'b0;
        H_OUT_L      = '0;
        H_OUT        = '0;
        if (state_q == ST_ISSUE) begin
            OP_CODE = CONTROL_SIZE'(phase_to_op(phase_q));
            OP_L    = l_count;
            OP_J    = j_count;
            if (phase_q == PH_ACT) OP_DATA = acc_q;
        end
        if (state_q == ST_STORE) begin
            H_OUT_ENABLE = 1'b1;
            H_OUT_L      = l_count;
            H_OUT        = act_q;
        end
    end

endmodule

// File: tb/tb_ntm_fnn_sequencer.sv
// Self-checking bench for ntm_fnn_sequencer: directed table rows with exact
// timing, a reset-abort sequence, and randomized passes against a queue model.
module tb_ntm_fnn_sequencer;

    localparam int IW  = $clog2(64 + 1);
    localparam int MAXS = 64;

    logic          CLK = 1'b0;
    logic          RST, START;
    logic [IW-1:0] SIZE_X_IN, SIZE_R_IN, SIZE_L_IN;
    logic          READY, OP_VALID, OP_READY;
    logic [3:0]    OP_CODE;
    logic [IW-1:0] OP_L, OP_J;
    logic [63:0]   OP_DATA;
    logic          RESULT_VALID;
    logic [63:0]   RESULT_IN;
    logic          H_OUT_ENABLE;
    logic [IW-1:0] H_OUT_L;
    logic [63:0]   H_OUT;

    ntm_fnn_sequencer #(
        .DATA_SIZE(64), .CONTROL_SIZE(4), .X(64), .R(64), .L(64)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START),
        .SIZE_X_IN(SIZE_X_IN), .SIZE_R_IN(SIZE_R_IN), .SIZE_L_IN(SIZE_L_IN),
        .READY(READY), .OP_VALID(OP_VALID), .OP_READY(OP_READY),
        .OP_CODE(OP_CODE), .OP_L(OP_L), .OP_J(OP_J), .OP_DATA(OP_DATA),
        .RESULT_VALID(RESULT_VALID), .RESULT_IN(RESULT_IN),
        .H_OUT_ENABLE(H_OUT_ENABLE), .H_OUT_L(H_OUT_L), .H_OUT(H_OUT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic report_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0]    code;
        logic [IW-1:0] l;
        logic [IW-1:0] j;
    } op_t;

    op_t         exp_ops[$];
    logic [63:0] exp_h[$];
    logic [63:0] model_acc;

    function automatic int clampi(input int v);
        return (v > MAXS) ? MAXS : v;
    endfunction

    // Expected op stream: per neuron W x SIZE_X, K x SIZE_R, U x SIZE_L, one B, one ACT.
    task automatic build_model(input int x, input int r, input int l);
        int cx, cr, cl;
        cx = clampi(x); cr = clampi(r); cl = clampi(l);
        exp_ops.delete();
        exp_h.delete();
        model_acc = '0;
        for (int n = 0; n < cl; n++) begin
            for (int j = 0; j < cx; j++) exp_ops.push_back('{4'd0, IW'(n), IW'(j)});
            for (int j = 0; j < cr; j++) exp_ops.push_back('{4'd1, IW'(n), IW'(j)});
            for (int j = 0; j < cl; j++) exp_ops.push_back('{4'd2, IW'(n), IW'(j)});
            exp_ops.push_back('{4'd3, IW'(n), IW'(0)});
            exp_ops.push_back('{4'd4, IW'(n), IW'(0)});
        end
    endtask

    // ---------------- arithmetic-unit responder ----------------
    bit          resp_en = 1'b0;
    int          res_mode = 0;      // 0: terms=1, ACT echo; 1: random; 2: terms=0x7FFF..., ACT echo
    int          stall_left = 0;
    int          stall_pct = 0;
    int          delay_max = 0;
    bit          spurious_en = 1'b0;
    bit          waiting = 1'b0;
    int          delay_left = 0;
    logic [63:0] resp_val;
    bit          resp_is_act;
    bit          held = 1'b0;
    op_t         held_op;
    logic [63:0] held_data;
    int          accept_cnt = 0;

    initial begin
        op_t cur, e;
        OP_READY     = 1'b0;
        RESULT_VALID = 1'b0;
        RESULT_IN    = '0;
        forever begin
            @(negedge CLK);
            RESULT_VALID = 1'b0;
            RESULT_IN    = '0;
            if (!resp_en) begin
                OP_READY = 1'b0;
                waiting  = 1'b0;
                held     = 1'b0;
            end else begin
                if (waiting) begin
                    if (delay_left > 0) begin
                        delay_left--;
                    end else begin
                        RESULT_VALID = 1'b1;
                        RESULT_IN    = resp_val;
                        waiting      = 1'b0;
                        if (resp_is_act) begin
                            exp_h.push_back(resp_val);
                            model_acc = '0;
                        end else begin
                            model_acc = model_acc + resp_val;
                        end
                    end
                end else if (spurious_en && $urandom_range(0, 3) == 0) begin
                    RESULT_VALID = 1'b1;
                    RESULT_IN    = {$urandom, $urandom};
                end

                if (OP_VALID) begin
                    cur = '{OP_CODE, OP_L, OP_J};
                    if (held) begin
                        check("stall_stable_fields", 64'(cur), 64'(held_op));
                        check("stall_stable_data", OP_DATA, held_data);
                    end
                    if (stall_left > 0 || (stall_pct > 0 && $urandom_range(0, 99) < stall_pct)) begin
                        if (stall_left > 0) stall_left--;
                        OP_READY = 1'b0;
                        if (!held) begin
                            held      = 1'b1;
                            held_op   = cur;
                            held_data = OP_DATA;
                        end
                    end else begin
                        OP_READY = 1'b1;
                        held     = 1'b0;
                        accept_cnt++;
                        if (exp_ops.size() == 0) begin
                            report_fail("unexpected_op");
                            resp_is_act = 1'b0;
                            resp_val    = '0;
                        end else begin
                            e = exp_ops.pop_front();
                            check("op_fields", 64'(cur), 64'(e));
                            if (e.code == 4'd4) begin
                                check("act_op_data", OP_DATA, model_acc);
                                resp_is_act = 1'b1;
                                resp_val    = (res_mode == 1) ? {$urandom, $urandom} : model_acc;
                            end else begin
                                check("op_data_zero", OP_DATA, 64'd0);
                                resp_is_act = 1'b0;
                                resp_val    = (res_mode == 0) ? 64'd1 :
                                              (res_mode == 1) ? {$urandom, $urandom} :
                                                                64'h7FFF_FFFF_FFFF_FFFF;
                            end
                        end
                        waiting    = 1'b1;
                        delay_left = (delay_max > 0) ? $urandom_range(0, delay_max) : 0;
                    end
                end else begin
                    OP_READY = (stall_pct > 0) ? 1'($urandom_range(0, 1)) : 1'b1;
                end
            end
        end
    end

    // ---------------- output monitor ----------------
    int          t0 = 0;
    int          store_cnt = 0;
    int          store0_rel = -1;
    int          store1_rel = -1;
    logic [63:0] h0_val = '0;
    int          exp_store_l = 0;
    int          ready_cnt = 0;
    int          ready_rel = -1;

    initial begin
        logic [63:0] eh;
        forever begin
            @(negedge CLK);
            if (H_OUT_ENABLE) begin
                store_cnt++;
                if (store_cnt == 1) begin
                    store0_rel = cyc - t0;
                    h0_val     = H_OUT;
                end
                if (store_cnt == 2) store1_rel = cyc - t0;
                if (exp_h.size() == 0) begin
                    report_fail("unexpected_store");
                end else begin
                    eh = exp_h.pop_front();
                    check("h_out", H_OUT, eh);
                end
                check("h_out_l", 64'(H_OUT_L), 64'(exp_store_l));
                exp_store_l++;
            end
            if (READY) begin
                ready_cnt++;
                ready_rel = cyc - t0;
            end
        end
    end

    // ---------------- pass driver ----------------
    task automatic clear_stats();
        store_cnt   = 0;
        store0_rel  = -1;
        store1_rel  = -1;
        exp_store_l = 0;
        ready_cnt   = 0;
        ready_rel   = -1;
        accept_cnt  = 0;
    endtask

    task automatic start_pass(input int x, input int r, input int l);
        clear_stats();
        build_model(x, r, l);
        @(negedge CLK);
        SIZE_X_IN = IW'(x);
        SIZE_R_IN = IW'(r);
        SIZE_L_IN = IW'(l);
        START     = 1'b1;
        t0        = cyc;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic run_pass(input int x, input int r, input int l, input bit rnd);
        bit done;
        start_pass(x, r, l);
        done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            if (READY) begin
                done = 1'b1;
            end else begin
                if (rnd) begin
                    START     = 1'($urandom_range(0, 1));
                    SIZE_X_IN = IW'($urandom_range(0, 127));
                    SIZE_R_IN = IW'($urandom_range(0, 127));
                    SIZE_L_IN = IW'($urandom_range(0, 127));
                end
                @(negedge CLK);
            end
        end
        START = 1'b0;
        if (!done) report_fail("ready_timeout");
        repeat (3) @(negedge CLK);
        check("ready_pulse_count", 64'(ready_cnt), 64'd1);
        check("store_count", 64'(store_cnt), 64'(clampi(l)));
        check("ops_left", 64'(exp_ops.size()), 64'd0);
        check("h_left", 64'(exp_h.size()), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"},    64'(READY), 64'd0);
        check({tag, "_op_valid"}, 64'(OP_VALID), 64'd0);
        check({tag, "_h_en"},     64'(H_OUT_ENABLE), 64'd0);
        check({tag, "_op_code"},  64'(OP_CODE), 64'd0);
        check({tag, "_op_l"},     64'(OP_L), 64'd0);
        check({tag, "_op_j"},     64'(OP_J), 64'd0);
        check({tag, "_op_data"},  OP_DATA, 64'd0);
        check({tag, "_h_l"},      64'(H_OUT_L), 64'd0);
        check({tag, "_h_out"},    H_OUT, 64'd0);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int          x, r, l, stall, mode;
        int          exp_store0, exp_store1, exp_ready, exp_ops;
        logic [63:0] exp_h0;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input string tag);
        res_mode   = v.mode;
        stall_left = v.stall;
        run_pass(v.x, v.r, v.l, 1'b0);
        check({tag, "_ready_cycle"}, 64'(ready_rel), 64'(v.exp_ready));
        check({tag, "_op_count"}, 64'(accept_cnt), 64'(v.exp_ops));
        if (v.exp_store0 >= 0) begin
            check({tag, "_store0_cycle"}, 64'(store0_rel), 64'(v.exp_store0));
            check({tag, "_h0"}, h0_val, v.exp_h0);
        end
        if (v.exp_store1 >= 0) check({tag, "_store1_cycle"}, 64'(store1_rel), 64'(v.exp_store1));
    endtask

    initial begin
        int rc0;
        bit hit;
        //          x    r    l  stall mode  st0  st1  rdy  ops  h0
        vecs[0] = '{2,   1,   2, 0,    0,    15,  30,  31,  14,  64'd6};
        vecs[1] = '{2,   1,   2, 3,    0,    18,  33,  34,  14,  64'd6};
        vecs[2] = '{2,   0,   2, 0,    0,    13,  26,  27,  12,  64'd5};   // 12 op cycles + STORE per neuron
        vecs[3] = '{0,   0,   0, 0,    0,    -1,  -1,  1,   0,   64'd0};
        vecs[4] = '{0,   0,   1, 0,    2,    7,   -1,  8,   3,   64'hFFFF_FFFF_FFFF_FFFE};
        vecs[5] = '{100, 100, 1, 0,    0,    263, -1,  264, 131, 64'd130};  // sizes clamp to 64

        RST = 1'b1; START = 1'b0;
        SIZE_X_IN = '0; SIZE_R_IN = '0; SIZE_L_IN = '0;
        repeat (3) @(negedge CLK);
        check_outputs_zero("reset");
        RST = 1'b0;
        resp_en = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset during the second neuron's WAIT (relative cycle 17).
        res_mode = 0;
        start_pass(2, 1, 2);
        hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            if (cyc - t0 == 17) hit = 1'b1;
            else @(negedge CLK);
        end
        if (!hit) report_fail("reset_window_timeout");
        check("wait_before_reset_op_valid", 64'(OP_VALID), 64'd0);
        RST = 1'b1;
        resp_en = 1'b0;
        @(negedge CLK);
        check_outputs_zero("midreset");
        RST = 1'b0;
        exp_ops.delete();
        exp_h.delete();
        model_acc = '0;
        rc0 = ready_cnt;
        repeat (6) @(negedge CLK);
        check("no_ready_after_abort", 64'(ready_cnt), 64'(rc0));
        check("idle_after_abort_op_valid", 64'(OP_VALID), 64'd0);
        resp_en = 1'b1;
        run_vec(vecs[0], "after_reset");

        // Randomized passes: stalls, result delays, spurious RESULT_VALID, START noise.
        res_mode    = 1;
        stall_pct   = 30;
        delay_max   = 3;
        spurious_en = 1'b1;
        for (int p = 0; p < 10; p++) begin
            run_pass($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
